// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared lane constants and FSM state type for the packed ALU
package alu_pkg;

    localparam int LANE_W = 4;
    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sat_lane_addsub.sv
// rtl/sat_lane_addsub.sv - combinational signed 4-bit saturating add/subtract lane
module sat_lane_addsub
    import alu_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sub,
    output logic [LANE_W-1:0] y,
    output logic              ovf
);

    logic [LANE_W-1:0] b_eff;
    logic [LANE_W-1:0] raw;
    logic              pos_ovf;
    logic              neg_ovf;

    // Subtraction is A + ~B + 1; the carry-in handles B = -8 correctly.
    assign b_eff   = sub ? ~b : b;
    assign raw     = a + b_eff + {{(LANE_W-1){1'b0}}, sub};
    assign pos_ovf = ~a[LANE_W-1] & ~b_eff[LANE_W-1] &  raw[LANE_W-1];
    assign neg_ovf =  a[LANE_W-1] &  b_eff[LANE_W-1] & ~raw[LANE_W-1];
    assign ovf     = pos_ovf | neg_ovf;
    assign y       = pos_ovf ? SAT_POS : (neg_ovf ? SAT_NEG : raw);

endmodule

// File: rtl/paddsb_serial.sv
// rtl/paddsb_serial.sv - nibble-serial packed saturating add/sub with start/done handshake
module paddsb_serial
    import alu_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sub,
    input  logic [LANES*LANE_W-1:0] a,
    input  logic [LANES*LANE_W-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*LANE_W-1:0] result,
    output logic [LANES-1:0]        sat
);

    localparam int IDX_W = $clog2(LANES);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [LANES*LANE_W-1:0] op_a;
    logic [LANES*LANE_W-1:0] op_b;
    logic                    op_sub;
    logic [LANE_W-1:0]       lane_y;
    logic                    lane_ovf;

    // One shared lane unit, fed by the lane selected by idx.
    sat_lane_addsub u_lane (
        .a   (op_a[idx*LANE_W +: LANE_W]),
        .b   (op_b[idx*LANE_W +: LANE_W]),
        .sub (op_sub),
        .y   (lane_y),
        .ovf (lane_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            result <= '0;
            sat    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        op_sub <= sub;
                        result <= '0;
                        sat    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result[idx*LANE_W +: LANE_W] <= lane_y;
                    sat[idx]                     <= lane_ovf;
                    idx                          <= idx + 1'b1;
                    if (idx == IDX_W'(LANES-1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
